// File: rtl/mul_seq_24bit_if.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_24bit_if
// Brief    : Request/response bundle between the control unit and the
//            sequential multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface mul_seq_24bit_if #(
    parameter int WIDTH = 24
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;

    modport master (
        output start, a, b, is_signed,
        input  busy, done, product, hi, lo
    );

    modport slave (
        input  start, a, b, is_signed,
        output busy, done, product, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mul_seq_24bit.sv
`default_nettype none
// ============================================================================
// Module   : mul_seq_24bit
// Brief    : Iterative shift-add WIDTHxWIDTH multiplier, fixed 25-cycle latency,
//            signed or unsigned operands.
// Revision : 1.0 - initial release
// ============================================================================
module mul_seq_24bit #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mul_seq_24bit_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [WIDTH-1:0]     r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_neg;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mag;

    // -2^(WIDTH-1) negates to itself, which read as unsigned is the right magnitude.
    assign w_abs_a = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_abs_b = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    // Carry lands in bit WIDTH and is shifted straight back into the accumulator.
    assign w_sum = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_mag = {r_acc, r_mplier};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_CALC;
            S_CALC:  if (r_cnt == c_last_iter) w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_sum[WIDTH:1];
                    r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
                    r_cnt    <= r_cnt + 1'b1;
                end
                S_FIN: begin
                    r_product <= r_neg ? (~w_mag + 1'b1) : w_mag;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.product = r_product;
    assign bus.hi      = r_product[2*WIDTH-1:WIDTH];
    assign bus.lo      = r_product[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_24bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_seq_24bit
// Brief    : Scoreboard bench for mul_seq_24bit with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_seq_24bit;

    localparam int WIDTH   = 24;
    localparam int LATENCY = 25;

    typedef struct {
        logic [47:0] prod;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    mul_seq_24bit_if #(.WIDTH(WIDTH)) bus ();

    mul_seq_24bit #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.busy && bus.done) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", bus.busy, bus.done);
            end
            if (bus.done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: product=%h with no operation outstanding", bus.product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (bus.product !== e.prod) begin
                        errors++;
                        $display("FAIL product: got %h required %h", bus.product, e.prod);
                    end
                    checks++;
                    if (bus.hi !== e.prod[47:24] || bus.lo !== e.prod[23:0]) begin
                        errors++;
                        $display("FAIL hi_lo: got %h/%h required %h/%h", bus.hi, bus.lo, e.prod[47:24], e.prod[23:0]);
                    end
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL latency: done at cycle %0d required %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check1(input string name, input logic [47:0] got, input logic [47:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Present operands for one edge; optionally register the expected result.
    task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic s,
                         input logic [47:0] exp_p, input bit track);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        if (track) sb.push_back('{prod: exp_p, cyc: cyc + LATENCY});
        bus.start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        cyc = 0;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.is_signed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("reset_busy", {47'd0, bus.busy}, 48'd0);
        check1("reset_done", {47'd0, bus.done}, 48'd0);
        check1("reset_product", bus.product, 48'd0);
        reset = 1'b0;

        // 3*5 with busy tracked across the whole operation
        issue(24'd3, 24'd5, 1'b0, 48'h00000000000F, 1'b1);
        for (int i = 0; i < LATENCY; i++) begin
            @(negedge clk);
            if (i == 0) check1("busy_after_start", {47'd0, bus.busy}, 48'd1);
            if (!bus.busy) begin
                errors++;
                $display("FAIL busy_window: busy=0 at offset %0d required 1", i);
            end
        end
        @(negedge clk);
        check1("busy_after_done", {47'd0, bus.busy}, 48'd0);
        drain();

        issue(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 1'b1);
        drain();
        issue(24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'h000000000001, 1'b1);
        drain();
        issue(24'hFFFFFD, 24'd7, 1'b1, 48'hFFFFFFFFFFEB, 1'b1);
        drain();
        issue(24'h800000, 24'h800000, 1'b1, 48'h400000000000, 1'b1);
        drain();
        issue(24'h800000, 24'h800000, 1'b0, 48'h400000000000, 1'b1);
        drain();

        // A second start while busy must be ignored
        issue(24'h123456, 24'h000010, 1'b0, 48'h000001234560, 1'b1);
        repeat (3) @(posedge clk);
        issue(24'd1, 24'd1, 1'b0, 48'd0, 1'b0);
        drain();
        check1("held_product", bus.product, 48'h000001234560);

        // Reset in the middle of an operation
        issue(24'd100, 24'd100, 1'b0, 48'd0, 1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check1("midreset_busy", {47'd0, bus.busy}, 48'd0);
        check1("midreset_done", {47'd0, bus.done}, 48'd0);
        check1("midreset_product", bus.product, 48'd0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        issue(24'd2, 24'd2, 1'b0, 48'd4, 1'b1);
        drain();

        // start held high: accepted every 26 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.is_signed = 1'b0;
        bus.a = 24'd6;
        bus.b = 24'd7;
        @(posedge clk);
        #1;
        sb.push_back('{prod: 48'h00000000002A, cyc: cyc + LATENCY});
        bus.a = 24'h001000;
        bus.b = 24'h001000;
        repeat (26) @(posedge clk);
        #1;
        sb.push_back('{prod: 48'h000001000000, cyc: cyc + LATENCY});
        bus.a = 24'hFFFFFF;
        bus.b = 24'd2;
        bus.is_signed = 1'b1;
        repeat (26) @(posedge clk);
        #1;
        sb.push_back('{prod: 48'hFFFFFFFFFFFE, cyc: cyc + LATENCY});
        bus.start = 1'b0;
        drain();
        repeat (30) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
